// File: rtl/riscv_core_axi_pkg.sv
// Shared AXI write-channel constants and the write-master FSM state type.
package riscv_core_axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    WR_IDLE   = 2'd0,
    WR_SEND   = 2'd1,
    WR_WAIT_B = 2'd2,
    WR_DONE   = 2'd3
  } wr_state_e;

endpackage

// File: rtl/riscv_core_axi_wr_lane_align.sv
// Moves LSB-justified store data and byte mask onto the AXI byte lanes
// selected by the low address bits.
module riscv_core_axi_wr_lane_align #(
  parameter int CORE_DATA_WIDTH = 32,
  parameter int AXI_DATA_WIDTH  = 64
) (
  input  logic [2:0]                 addr,
  input  logic [CORE_DATA_WIDTH-1:0] data,
  input  logic [7:0]                 strobe,
  output logic [AXI_DATA_WIDTH-1:0]  wdata,
  output logic [7:0]                 wstrb
);

  logic [AXI_DATA_WIDTH-1:0] data_ext;

  // Dword stores only carry 32 bits from the core; the upper lanes read as zero.
  assign data_ext = AXI_DATA_WIDTH'(data);
  assign wdata    = data_ext << {addr, 3'b000};
  assign wstrb    = strobe << addr;

endmodule

// File: rtl/riscv_core_dcache_axi_write.sv
// Single-beat AXI4 write master for dcache write-through stores.
// Optional watchdog on AW/W/B progress: define AXI_WR_TIMEOUT_EN.
module riscv_core_dcache_axi_write #(
  parameter int ADDR_WIDTH      = 32,
  parameter int CORE_DATA_WIDTH = 32,
  parameter int AXI_DATA_WIDTH  = 64,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_mem_write_valid,
  input  logic [ADDR_WIDTH-1:0]      i_mem_write_address,
  input  logic [CORE_DATA_WIDTH-1:0] i_mem_write_data,
  input  logic [7:0]                 i_mem_write_strobe,
  input  logic [1:0]                 i_mem_write_size,
  output logic                       o_mem_write_done,
  output logic                       o_mem_write_err,
  output logic [ADDR_WIDTH-1:0]      o_awaddr,
  output logic                       o_awvalid,
  input  logic                       i_awready,
  output logic [7:0]                 o_awlen,
  output logic [2:0]                 o_awsize,
  output logic [1:0]                 o_awburst,
  output logic [AXI_DATA_WIDTH-1:0]  o_wdata,
  output logic [7:0]                 o_wstrb,
  output logic                       o_wlast,
  output logic                       o_wvalid,
  input  logic                       i_wready,
  input  logic                       i_bvalid,
  input  logic [1:0]                 i_bresp,
  output logic                       o_bready,
  output logic [1:0]                 o_dbg_state
);
  import riscv_core_axi_pkg::*;

  // Handshakes: a beat transfers on a rising edge where valid & ready are both
  // high; valid never drops and payload never changes until that edge.

  wr_state_e                 state_q, state_d;
  logic                      awvalid_q, awvalid_d;
  logic                      wvalid_q, wvalid_d;
  logic                      bready_q, bready_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;
  logic                      aw_done_q, aw_done_d;
  logic                      w_done_q, w_done_d;
  logic [ADDR_WIDTH-1:0]     awaddr_q, awaddr_d;
  logic [2:0]                awsize_q, awsize_d;
  logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [7:0]                wstrb_q, wstrb_d;

  logic [AXI_DATA_WIDTH-1:0] align_wdata;
  logic [7:0]                align_wstrb;
  logic                      aw_hs, w_hs, b_hs;
  logic                      aw_fin, w_fin;
  logic                      accept;
  logic                      tmo_hit;

  riscv_core_axi_wr_lane_align #(
    .CORE_DATA_WIDTH (CORE_DATA_WIDTH),
    .AXI_DATA_WIDTH  (AXI_DATA_WIDTH)
  ) u_lane_align (
    .addr   (i_mem_write_address[2:0]),
    .data   (i_mem_write_data),
    .strobe (i_mem_write_strobe),
    .wdata  (align_wdata),
    .wstrb  (align_wstrb)
  );

  assign aw_hs  = awvalid_q & i_awready;
  assign w_hs   = wvalid_q & i_wready;
  assign b_hs   = bready_q & i_bvalid;
  assign aw_fin = aw_done_q | aw_hs;
  assign w_fin  = w_done_q | w_hs;
  assign accept = (state_q == WR_IDLE) & i_mem_write_valid;

`ifdef AXI_WR_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

  assign tmo_hit = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES));

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (accept) begin
      tmo_cnt_d = '0;
    end else if ((state_q == WR_SEND) || (state_q == WR_WAIT_B)) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  logic unused_tmo_cfg;

  assign tmo_hit        = 1'b0;
  assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
`endif

  // Only BRESP[1] distinguishes an error; OKAY and EXOKAY both succeed.
  logic unused_bresp;
  assign unused_bresp = i_bresp[0];

  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    awaddr_d  = awaddr_q;
    awsize_d  = awsize_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      WR_IDLE: begin
        if (accept) begin
          awaddr_d  = i_mem_write_address;
          awsize_d  = {1'b0, i_mem_write_size};
          wdata_d   = align_wdata;
          wstrb_d   = align_wstrb;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = WR_SEND;
        end
      end

      WR_SEND: begin
        aw_done_d = aw_fin;
        w_done_d  = w_fin;
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        // A completing handshake wins over a watchdog expiry in the same cycle.
        if (aw_fin && w_fin) begin
          bready_d = 1'b1;
          state_d  = WR_WAIT_B;
        end else if (tmo_hit) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b0;
          done_d    = 1'b1;
          err_d     = 1'b1;
          state_d   = WR_DONE;
        end
      end

      WR_WAIT_B: begin
        if (b_hs) begin
          bready_d = 1'b0;
          done_d   = 1'b1;
          err_d    = i_bresp[1];
          state_d  = WR_DONE;
        end else if (tmo_hit) begin
          bready_d = 1'b0;
          done_d   = 1'b1;
          err_d    = 1'b1;
          state_d  = WR_DONE;
        end
      end

      WR_DONE: begin
        state_d = WR_IDLE;
      end

      default: begin
        state_d = WR_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= WR_IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      awaddr_q  <= '0;
      awsize_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      done_q    <= done_d;
      err_q     <= err_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      awaddr_q  <= awaddr_d;
      awsize_q  <= awsize_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
    end
  end

  assign o_mem_write_done = done_q;
  assign o_mem_write_err  = err_q;
  assign o_awaddr         = awaddr_q;
  assign o_awvalid        = awvalid_q;
  assign o_awlen          = 8'd0;
  assign o_awsize         = awsize_q;
  assign o_awburst        = AXI_BURST_INCR;
  assign o_wdata          = wdata_q;
  assign o_wstrb          = wstrb_q;
  assign o_wlast          = wvalid_q;
  assign o_wvalid         = wvalid_q;
  assign o_bready         = bready_q;
  assign o_dbg_state      = state_q;

endmodule

// File: tb/tb_riscv_core_dcache_axi_write.sv
// Bench for riscv_core_dcache_axi_write: vector table with a per-store
// scoreboard, random stores, reset during WAIT_B, optional watchdog case.
module tb_riscv_core_dcache_axi_write;
  import riscv_core_axi_pkg::*;

  localparam int W = 108;  // {awaddr[31:0], awsize[2:0], wdata[63:0], wstrb[7:0], err}

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [7:0]  strb;
    logic [1:0]  size;
    int          aw_dly;
    int          w_dly;
    int          b_at;
    logic [1:0]  bresp;
    logic [63:0] exp_wdata;
    logic [7:0]  exp_wstrb;
    logic        exp_err;
    int          exp_done;
    int          exp_b;
  } vec_t;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_mem_write_valid;
  logic [31:0] i_mem_write_address;
  logic [31:0] i_mem_write_data;
  logic [7:0]  i_mem_write_strobe;
  logic [1:0]  i_mem_write_size;
  logic        o_mem_write_done;
  logic        o_mem_write_err;
  logic [31:0] o_awaddr;
  logic        o_awvalid;
  logic        i_awready;
  logic [7:0]  o_awlen;
  logic [2:0]  o_awsize;
  logic [1:0]  o_awburst;
  logic [63:0] o_wdata;
  logic [7:0]  o_wstrb;
  logic        o_wlast;
  logic        o_wvalid;
  logic        i_wready;
  logic        i_bvalid;
  logic [1:0]  i_bresp;
  logic        o_bready;
  logic [1:0]  o_dbg_state;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  vec_t vecs[6];

  riscv_core_dcache_axi_write #(
    .ADDR_WIDTH      (32),
    .CORE_DATA_WIDTH (32),
    .AXI_DATA_WIDTH  (64),
    .TIMEOUT_CYCLES  (8)
  ) dut (
    .i_clk               (i_clk),
    .i_rst_n             (i_rst_n),
    .i_mem_write_valid   (i_mem_write_valid),
    .i_mem_write_address (i_mem_write_address),
    .i_mem_write_data    (i_mem_write_data),
    .i_mem_write_strobe  (i_mem_write_strobe),
    .i_mem_write_size    (i_mem_write_size),
    .o_mem_write_done    (o_mem_write_done),
    .o_mem_write_err     (o_mem_write_err),
    .o_awaddr            (o_awaddr),
    .o_awvalid           (o_awvalid),
    .i_awready           (i_awready),
    .o_awlen             (o_awlen),
    .o_awsize            (o_awsize),
    .o_awburst           (o_awburst),
    .o_wdata             (o_wdata),
    .o_wstrb             (o_wstrb),
    .o_wlast             (o_wlast),
    .o_wvalid            (o_wvalid),
    .i_wready            (i_wready),
    .i_bvalid            (i_bvalid),
    .i_bresp             (i_bresp),
    .o_bready            (o_bready),
    .o_dbg_state         (o_dbg_state)
  );

  // Clock and reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    i_mem_write_valid   = 1'b0;
    i_mem_write_address = '0;
    i_mem_write_data    = '0;
    i_mem_write_strobe  = '0;
    i_mem_write_size    = '0;
    i_awready           = 1'b0;
    i_wready            = 1'b0;
    i_bvalid            = 1'b0;
    i_bresp             = '0;
  endtask

  // Driver plus AXI slave: called at a negedge while the DUT is idle.
  task automatic run_store(input vec_t v);
    int cyc;
    int aw_n;
    int w_n;
    int b_n;
    bit fin;
    logic [W-1:0] e;
    chk("idle_done", {63'd0, o_mem_write_done}, 64'd0);
    chk("idle_awvalid", {63'd0, o_awvalid}, 64'd0);
    i_mem_write_valid   = 1'b1;
    i_mem_write_address = v.addr;
    i_mem_write_data    = v.data;
    i_mem_write_strobe  = v.strb;
    i_mem_write_size    = v.size;
    exp_q.push_back({v.addr, 1'b0, v.size, v.exp_wdata, v.exp_wstrb, v.exp_err});
    e = exp_q[0];
    cyc = 0; aw_n = 0; w_n = 0; b_n = 0; fin = 0;
    while (!fin && cyc < 100) begin
      @(posedge i_clk);
      @(negedge i_clk);
      cyc++;
      if (o_mem_write_done) begin
        idle_inputs();
        e = exp_q.pop_front();
        chk("done_err", {63'd0, o_mem_write_err}, {63'd0, e[0]});
        if (v.exp_done >= 0) chk("done_cycle", 64'(cyc), 64'(v.exp_done));
        chk("aw_count", 64'(aw_n), 64'd1);
        chk("w_count", 64'(w_n), 64'd1);
        chk("b_count", 64'(b_n), 64'(v.exp_b));
        fin = 1;
      end else begin
        chk("no_err_wo_done", {63'd0, o_mem_write_err}, 64'd0);
        i_awready = (cyc > v.aw_dly);
        i_wready  = (cyc > v.w_dly);
        i_bvalid  = (b_n == 0) && (cyc >= v.b_at);
        i_bresp   = i_bvalid ? v.bresp : 2'b00;
        if (o_bready) chk("bready_after_hs", 64'(aw_n + w_n), 64'd2);
        if (aw_n > 0) chk("awvalid_dropped", {63'd0, o_awvalid}, 64'd0);
        if (w_n > 0) chk("wvalid_dropped", {63'd0, o_wvalid}, 64'd0);
        if (o_awvalid) begin
          chk("awaddr", {32'd0, o_awaddr}, {32'd0, e[107:76]});
          chk("awsize", {61'd0, o_awsize}, {61'd0, e[75:73]});
          chk("awlen_burst", {54'd0, o_awlen, o_awburst}, {54'd0, 8'd0, 2'b01});
          if (i_awready) aw_n++;
        end
        if (o_wvalid) begin
          chk("wdata", o_wdata, e[72:9]);
          chk("wstrb_wlast", {55'd0, o_wstrb, o_wlast}, {55'd0, e[8:1], 1'b1});
          if (i_wready) w_n++;
        end
        if (o_bready && i_bvalid) b_n++;
      end
    end
    if (!fin) begin
      chk("done_timeout", 64'd0, 64'd1);
      void'(exp_q.pop_front());
      idle_inputs();
    end
  endtask

  initial begin
    vec_t r;
    int off;
    int nbytes;
    idle_inputs();
    i_rst_n = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("rst_ctrl", {58'd0, o_mem_write_done, o_mem_write_err, o_awvalid, o_wvalid,
                     o_bready, o_wlast}, 64'd0);
    chk("rst_awaddr_size", {29'd0, o_awaddr, o_awsize}, 64'd0);
    chk("rst_wdata", o_wdata, 64'd0);
    chk("rst_wstrb_state", {54'd0, o_wstrb, o_dbg_state}, 64'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    vecs[0] = '{32'h1004, 32'hDEADBEEF, 8'h0F, 2'd2, 0, 0, 0, 2'b00,
                64'hDEADBEEF_00000000, 8'hF0, 1'b0, 3, 1};
    vecs[1] = '{32'h2003, 32'h000000A5, 8'h01, 2'd0, 4, 0, 0, 2'b00,
                64'h00000000_A5000000, 8'h08, 1'b0, 7, 1};
    vecs[2] = '{32'h3010, 32'h12345678, 8'h0F, 2'd2, 0, 0, 5, 2'b10,
                64'h00000000_12345678, 8'h0F, 1'b1, 6, 1};
    vecs[3] = '{32'h4006, 32'h0000BEEF, 8'h03, 2'd1, 0, 3, 1, 2'b00,
                64'hBEEF0000_00000000, 8'hC0, 1'b0, 6, 1};
    vecs[4] = '{32'h5008, 32'hCAFEF00D, 8'hFF, 2'd3, 2, 1, 0, 2'b11,
                64'h00000000_CAFEF00D, 8'hFF, 1'b1, 5, 1};
    vecs[5] = '{32'h6001, 32'h0000003C, 8'h01, 2'd0, 1, 2, 0, 2'b01,
                64'h00000000_00003C00, 8'h02, 1'b0, 5, 1};

    // Back-to-back: each store starts in the IDLE cycle right after done.
    for (int i = 0; i < 6; i++) begin
      run_store(vecs[i]);
      @(negedge i_clk);
    end

    for (int n = 0; n < 10; n++) begin
      r.size   = 2'($urandom_range(0, 3));
      nbytes   = 1 << r.size;
      off      = ($urandom_range(0, 7) / nbytes) * nbytes;
      r.addr   = {$urandom_range(0, 65535), 16'h0} | 32'(off);
      r.data   = $urandom();
      if (r.size != 2'd3) r.data = r.data & ((32'd1 << (8 * nbytes)) - 32'd1);
      r.strb   = 8'((9'd1 << nbytes) - 9'd1);
      r.exp_wdata = '0;
      r.exp_wstrb = '0;
      for (int b = 0; b < 8; b++) begin
        if (b >= off && b < off + nbytes) begin
          r.exp_wstrb[b] = 1'b1;
          if (b - off < 4) r.exp_wdata[8*b +: 8] = r.data[8*(b-off) +: 8];
        end
      end
      r.aw_dly   = $urandom_range(0, 3);
      r.w_dly    = $urandom_range(0, 3);
      r.b_at     = $urandom_range(0, 6);
      r.bresp    = 2'($urandom_range(0, 3));
      r.exp_err  = r.bresp[1];
      r.exp_done = -1;
      r.exp_b    = 1;
      run_store(r);
      @(negedge i_clk);
    end

    // Reset while waiting for B clears every output without a clock edge.
    i_mem_write_valid   = 1'b1;
    i_mem_write_address = 32'h7004;
    i_mem_write_data    = 32'h55AA55AA;
    i_mem_write_strobe  = 8'h0F;
    i_mem_write_size    = 2'd2;
    i_awready           = 1'b1;
    i_wready            = 1'b1;
    repeat (2) @(negedge i_clk);
    chk("waitb_state", {62'd0, o_dbg_state}, {62'd0, WR_WAIT_B});
    chk("waitb_bready", {63'd0, o_bready}, 64'd1);
    i_rst_n = 1'b0;
    #1;
    chk("async_rst_ctrl", {59'd0, o_mem_write_done, o_mem_write_err, o_awvalid,
                           o_wvalid, o_bready}, 64'd0);
    chk("async_rst_data", {o_wdata[31:0], o_awaddr}, 64'd0);
    chk("async_rst_state", {54'd0, o_wstrb, o_dbg_state}, 64'd0);
    idle_inputs();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    run_store(vecs[0]);
    @(negedge i_clk);

`ifdef AXI_WR_TIMEOUT_EN
    r = vecs[0];
    r.b_at     = 1000;
    r.exp_err  = 1'b1;
    r.exp_done = 10;
    r.exp_b    = 0;
    run_store(r);
    @(negedge i_clk);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
